axi_arbiter_w: RTL
==================

AXI_ARBITER_W -- requirements
Module: axi_arbiter_w

Interface
REQ-001 SHALL provide port ACLK  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL provide port ARESET  input  1  reset, synchronous and active-high.
REQ-003 SHALL provide port m_AWVALID  input  4  AWVALID from masters 3..0 (bit i = master i).
REQ-004 SHALL provide port s_AWVALID  input  1  AWVALID of the granted master, after the write mux.
REQ-005 SHALL provide port s_AWREADY  input  1  slave AWREADY.
REQ-006 SHALL provide port s_WVALID  input  1  WVALID of the granted master, after the write mux.
REQ-007 SHALL provide port s_WREADY  input  1  slave WREADY.
REQ-008 SHALL provide port s_WLAST  input  1  WLAST of the granted master, after the write mux.
REQ-009 SHALL provide port s_BVALID  input  1  slave BVALID.
REQ-010 SHALL provide port s_BREADY  input  1  BREADY of the granted master, after the response mux.
REQ-011 SHALL provide port m_wgrnt  output  4  one-hot write grant; all-zero when no master is granted.
REQ-012 SHALL provide port grant_id  output  2  binary index of the granted master, used as the mux select.
REQ-013 SHALL provide port busy  output  1  high while a write transaction owns the slave.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, RESP; m_wgrnt SHALL be registered and SHALL change only on state transitions.
REQ-015 IDLE, any m_AWVALID bit set: SHALL select the winner by round-robin and go to ADDR next cycle. The search starts at (last_id+1) mod 4 and wraps 0..3.
REQ-016 Grant latency SHALL be exactly 1 cycle: a request sampled at edge N drives m_wgrnt/grant_id/busy from edge N+1.
REQ-017 IDLE with m_AWVALID==0: SHALL stay in IDLE with m_wgrnt=0000 and busy=0; grant_id SHALL hold last_id.
REQ-018 ADDR: SHALL set sticky flag aw_done on s_AWVALID&&s_AWREADY.
REQ-019 ADDR: SHALL set sticky flag w_done on s_WVALID&&s_WREADY&&s_WLAST. W-before-AW ordering SHALL be accepted.
REQ-020 ADDR -> RESP when both flags are set, or become set, in the same cycle; the AW and last-W handshake in a single cycle SHALL also move to RESP.
REQ-021 RESP: on s_BVALID&&s_BREADY SHALL go to IDLE, set last_id=grant_id, and clear aw_done/w_done; m_wgrnt SHALL be 0000 in the following cycle.
REQ-022 Grant SHALL NOT change during ADDR/RESP regardless of m_AWVALID activity, including deassertion of the granted master's request.
REQ-023 A master re-requesting in the cycle after its own B handshake SHALL win only if no other master on the round-robin path is requesting.
REQ-024 W beats without WLAST SHALL NOT affect state; s_BVALID in ADDR SHALL be ignored.
REQ-025 m_wgrnt SHALL always be one-hot or zero; busy SHALL equal |m_wgrnt.

Reset
REQ-026 ARESET=1 at an edge: state=IDLE, m_wgrnt=0000, busy=0, aw_done=w_done=0, last_id=3, grant_id=3. The first arbitration therefore favours master 0.
REQ-027 ARESET asserted mid-transaction (ADDR or RESP) SHALL abort it immediately with the reset values above. No B handshake is required afterwards.
REQ-028 ARESET SHALL take priority over every other input in the same cycle.

Verification
REQ-029 Reset, then m_AWVALID=1111 held -> m_wgrnt sequence 0001, 0010, 0100, 1000, 0001 across five complete transactions.
REQ-030 Master 2 alone: AW handshake cycle 2, 4 W beats with WLAST on beat 4, B handshake cycle 9 -> busy high cycles 1..9, m_wgrnt=0100 throughout, 0000 at cycle 10.
REQ-031 W-last handshake before AW handshake (2 cycles earlier) -> stays in ADDR until the AW handshake, then RESP; grant unchanged.
REQ-032 AW and last-W handshake in the same cycle -> RESP next cycle; B handshake -> IDLE.
REQ-033 ARESET pulsed during RESP with m_AWVALID=1000 -> m_wgrnt=0000 the cycle after reset; on release, master 3 is granted (only requester).
REQ-034 Master 1 finishes while masters 1 and 3 both request -> master 3 is granted next.

Source files
------------

// File: rtl/axi_arbiter_w.sv
// Write-channel arbiter: four AXI masters share one slave write port.
// A round-robin winner is picked in IDLE and holds the grant until the
// AW handshake, the last W beat and the B handshake have all completed.
module axi_arbiter_w (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic [3:0] m_AWVALID,
  input  logic       s_AWVALID,
  input  logic       s_AWREADY,
  input  logic       s_WVALID,
  input  logic       s_WREADY,
  input  logic       s_WLAST,
  input  logic       s_BVALID,
  input  logic       s_BREADY,
  output logic [3:0] m_wgrnt,
  output logic [1:0] grant_id,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] wgrnt_next;
  logic [1:0] grant_id_next;
  logic       busy_next;
  logic       aw_done;
  logic       aw_done_next;
  logic       w_done;
  logic       w_done_next;
  logic [1:0] last_id;
  logic [1:0] last_id_next;
  logic [1:0] pick;
  logic       aw_hs;
  logic       w_hs;
  logic       b_hs;

  // Round-robin search: the master right after `last` has top priority,
  // `last` itself comes last. Scanning from far to near lets the nearest
  // requester overwrite earlier candidates.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] req);
    logic [1:0] sel;
    logic [1:0] idx;
    sel = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        sel = idx;
      end
    end
    return sel;
  endfunction

  // Binary master index to one-hot grant vector.
  function automatic logic [3:0] to_onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

  assign pick  = rr_pick(last_id, m_AWVALID);
  assign aw_hs = s_AWVALID && s_AWREADY;
  assign w_hs  = s_WVALID && s_WREADY && s_WLAST;
  assign b_hs  = s_BVALID && s_BREADY;

  // Next-state and next-output logic; every register holds unless a transition updates it.
  always_comb begin
    state_next    = state;
    wgrnt_next    = m_wgrnt;
    grant_id_next = grant_id;
    busy_next     = busy;
    aw_done_next  = aw_done;
    w_done_next   = w_done;
    last_id_next  = last_id;
    case (state)
      IDLE: begin
        if (|m_AWVALID) begin
          state_next    = ADDR;
          wgrnt_next    = to_onehot(pick);
          grant_id_next = pick;
          busy_next     = 1'b1;
        end else begin
          wgrnt_next    = 4'b0000;
          grant_id_next = last_id;
          busy_next     = 1'b0;
        end
      end
      ADDR: begin
        // Flags are sticky so AW and last-W may complete in either order.
        aw_done_next = aw_done || aw_hs;
        w_done_next  = w_done || w_hs;
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_next = RESP;
        end else begin
          state_next = ADDR;
        end
      end
      RESP: begin
        if (b_hs) begin
          state_next   = IDLE;
          wgrnt_next   = 4'b0000;
          busy_next    = 1'b0;
          last_id_next = grant_id;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next    = IDLE;
        wgrnt_next    = 4'b0000;
        grant_id_next = last_id;
        busy_next     = 1'b0;
        aw_done_next  = 1'b0;
        w_done_next   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      m_wgrnt  <= 4'b0000;
      grant_id <= 2'd3;
      busy     <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      last_id  <= 2'd3;
    end else begin
      state    <= state_next;
      m_wgrnt  <= wgrnt_next;
      grant_id <= grant_id_next;
      busy     <= busy_next;
      aw_done  <= aw_done_next;
      w_done   <= w_done_next;
      last_id  <= last_id_next;
    end
  end

endmodule
